dac_buf_ram: RTL and testbench



---
 rtl/dac_buf_ram.sv | 46 ++++
 tb/tb_dac_buf_ram.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dac_buf_ram.sv
// Sample buffer between the MCU bus and the DAC serializer: byte-wide write port,
// 32-bit read-first registered read port, one stereo sample pair per word.
module dac_buf_ram #(
  parameter int ADDRA_W   = 11,
  parameter int ADDRB_W   = 9,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               wea,
  input  logic [ADDRA_W-1:0] addra,
  input  logic [7:0]         dina,
  input  logic [ADDRB_W-1:0] addrb,
  output logic [31:0]        doutb
);

  localparam int         DEPTHB    = 2 ** ADDRB_W;
  localparam logic [7:0] INIT_BYTE = INIT_ZERO ? 8'h00 : 8'hxx;

  logic [31:0] rd_word_s;

  // Four byte lanes: lane g holds every byte whose address ends in g, so a
  // single read row yields the little-endian word {lane3, lane2, lane1, lane0}.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_r [DEPTHB] = '{default: INIT_BYTE};

    // Byte write into this lane when the low address bits select it.
    always_ff @(posedge clkin) begin
      if (wea && (addra[1:0] == 2'(g))) begin
        lane_r[addra[ADDRA_W-1:2]] <= dina;
      end
    end

    assign rd_word_s[8*g +: 8] = lane_r[addrb];
  end

  // Output register: samples pre-write contents, so collisions read first.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      doutb <= 32'h0000_0000;
    end else begin
      doutb <= rd_word_s;
    end
  end

endmodule

// File: tb/tb_dac_buf_ram.sv
// Directed plus randomized check of dac_buf_ram against a byte-array reference model.
module tb_dac_buf_ram;

  logic        clkin;
  logic        reset;
  logic        wea;
  logic [10:0] addra;
  logic [7:0]  dina;
  logic [8:0]  addrb;
  logic [31:0] doutb;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [2048];
  logic [31:0] model_dout;

  dac_buf_ram #(.ADDRA_W(11), .ADDRB_W(9), .INIT_ZERO(1'b1)) dut (
    .clkin(clkin),
    .reset(reset),
    .wea  (wea),
    .addra(addra),
    .dina (dina),
    .addrb(addrb),
    .doutb(doutb)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  function automatic logic [31:0] word_of(input logic [8:0] w);
    return {model[{w, 2'b11}], model[{w, 2'b10}], model[{w, 2'b01}], model[{w, 2'b00}]};
  endfunction

  // One clock: the read sees memory before this edge's write; reset forces zero.
  task automatic tick();
    logic [31:0] exp_word;
    exp_word = reset ? 32'h0000_0000 : word_of(addrb);
    if (wea) model[addra] = dina;
    @(posedge clkin);
    #1;
    model_dout = exp_word;
  endtask

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (doutb === exp) else begin
      errors++;
      $error("FAIL %s: doutb=%h expected=%h", tag, doutb, exp);
    end
  endtask

  initial begin
    logic [7:0] pack_vals [4];
    logic [7:0] top_vals [4];
    pack_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    top_vals  = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 2048; i++) model[i] = 8'h00;
    model_dout = 32'h0000_0000;

    reset = 1'b1; wea = 1'b0; addra = 11'h000; dina = 8'h00; addrb = 9'h000;
    #3;
    check("reset_init", 32'h0000_0000);
    tick();
    check("reset_held", 32'h0000_0000);

    reset = 1'b0; addrb = 9'h005;
    tick();
    check("init_zero", 32'h0000_0000);

    // Pack and order
    for (int i = 0; i < 4; i++) begin
      wea = 1'b1; addra = 11'(i); dina = pack_vals[i];
      tick();
    end
    wea = 1'b0; addrb = 9'h000;
    tick();
    check("pack", 32'h4433_2211);

    // Top of memory, no aliasing onto word 0
    for (int i = 0; i < 4; i++) begin
      wea = 1'b1; addra = 11'h7FC + 11'(i); dina = top_vals[i];
      tick();
    end
    wea = 1'b0; addrb = 9'h1FF;
    tick();
    check("top_word", 32'hDDCC_BBAA);
    addrb = 9'h000;
    tick();
    check("word0_no_alias", 32'h4433_2211);

    // Write-enable gating
    wea = 1'b0; addra = 11'h001; dina = 8'hFF;
    tick();
    check("wea_low_no_write", 32'h4433_2211);
    wea = 1'b1;
    tick();
    check("wea_pulse_read_first", 32'h4433_2211);
    wea = 1'b0;
    tick();
    check("wea_pulse_written", 32'h4433_FF11);

    // Collision: read-first on the same word
    wea = 1'b1; addra = 11'h003; dina = 8'h55;
    tick();
    check("collision_old", 32'h4433_FF11);
    wea = 1'b0;
    tick();
    check("collision_new", 32'h5533_FF11);

    // Asynchronous reset between edges, writes still land
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'h0000_0000);
    model_dout = 32'h0000_0000;
    wea = 1'b1; addra = 11'h400; dina = 8'h77;
    tick();
    check("write_in_reset", 32'h0000_0000);
    wea = 1'b0; addrb = 9'h1FF;
    #2;
    reset = 1'b0;
    tick();
    check("reset_release", 32'hDDCC_BBAA);
    addrb = 9'h100;
    tick();
    check("reset_write_kept", 32'h0000_0077);

    // Randomized writes/reads with frequent same-word collisions
    for (int n = 0; n < 400; n++) begin
      wea   = 1'($urandom_range(0, 1));
      addra = 11'($urandom);
      dina  = 8'($urandom);
      addrb = ($urandom_range(0, 3) == 0) ? addra[10:2] : 9'($urandom);
      tick();
      check("random", model_dout);
    end

    // Latency sweep over a full fill pattern
    wea = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      addra = 11'(a);
      dina  = 8'(a) ^ {5'b00000, 3'(a >> 8)};
      tick();
    end
    wea = 1'b0;
    for (int w = 0; w < 512; w++) begin
      addrb = 9'(w);
      tick();
      if (w > 0) check("sweep", model_dout);
    end
    tick();
    check("sweep_last", {8'hFF ^ 8'h07, 8'hFE ^ 8'h07, 8'hFD ^ 8'h07, 8'hFC ^ 8'h07});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
